// File: rtl/mc_pkg.sv
// mc_pkg: state codes, opcode/funct constants and datapath mux encodings
// shared by the multi-cycle controller and the datapath.
package mc_pkg;
   typedef enum logic [2:0] {
      S_FETCH = 3'd0, S_DECODE = 3'd1, S_EXE = 3'd2, S_MEM = 3'd3, S_WB = 3'd4
   } state_t;

   typedef enum logic [3:0] {
      C_ADDU, C_SUBU, C_ORI, C_LUI, C_LW, C_SW, C_BEQ, C_JAL, C_JR, C_NOP, C_ILL
   } cls_t;

   localparam logic [5:0] OP_R   = 6'h00;
   localparam logic [5:0] OP_ORI = 6'h0d;
   localparam logic [5:0] OP_LUI = 6'h0f;
   localparam logic [5:0] OP_LW  = 6'h23;
   localparam logic [5:0] OP_SW  = 6'h2b;
   localparam logic [5:0] OP_BEQ = 6'h04;
   localparam logic [5:0] OP_JAL = 6'h03;
   localparam logic [5:0] F_ADDU = 6'h21;
   localparam logic [5:0] F_SUBU = 6'h23;
   localparam logic [5:0] F_JR   = 6'h08;
   localparam logic [5:0] F_NOP  = 6'h00;

   localparam logic [1:0] RD_RT = 2'b00, RD_RD = 2'b01, RD_RA = 2'b10;
   localparam logic [1:0] WD_ALU = 2'b00, WD_DM = 2'b01, WD_PC = 2'b10;
   localparam logic [1:0] ALU_ADD = 2'b00, ALU_SUB = 2'b01, ALU_OR = 2'b10;
   localparam logic [1:0] EXT_ZERO = 2'b00, EXT_SIGN = 2'b01, EXT_LUI = 2'b10;
   localparam logic [1:0] PC_PLUS4 = 2'b00, PC_BR = 2'b01, PC_JAL = 2'b10, PC_RS = 2'b11;

   typedef struct packed {
      logic       pc_we;
      logic       ir_we;
      logic       grf_we;
      logic       dm_we;
      logic [1:0] reg_dst;
      logic [1:0] wd_sel;
      logic       alu_b_sel;
      logic [1:0] alu_op;
      logic [1:0] ext_op;
      logic [1:0] pc_src;
   } ctl_t;
endpackage

// File: rtl/mc_decode.sv
// mc_decode: maps op/funct to an instruction class and flags undecodable encodings.
module mc_decode import mc_pkg::*; (
   input  logic [5:0] op,
   input  logic [5:0] funct,
   output cls_t       cls,
   output logic       ill
);
   always_comb begin
      cls = C_ILL;
      case (op)
         OP_R:    cls = funct == F_ADDU ? C_ADDU : funct == F_SUBU ? C_SUBU :
                        funct == F_JR ? C_JR : funct == F_NOP ? C_NOP : C_ILL;
         OP_ORI:  cls = C_ORI;
         OP_LUI:  cls = C_LUI;
         OP_LW:   cls = C_LW;
         OP_SW:   cls = C_SW;
         OP_BEQ:  cls = C_BEQ;
         OP_JAL:  cls = C_JAL;
         default: cls = C_ILL;
      endcase
   end
   assign ill = cls == C_ILL;
endmodule

// File: rtl/mc_ctrl.sv
// mc_ctrl: multi-cycle FETCH/DECODE/EXE/MEM/WB controller for the shared MIPS datapath,
// with DM latency counter, retired-instruction counter and sticky illegal flag.
module mc_ctrl import mc_pkg::*; #(
   parameter int MEM_LAT = 1,
   parameter int CNT_W   = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [5:0]       op,
   input  logic [5:0]       funct,
   input  logic             zero,
   output logic             pc_we,
   output logic             ir_we,
   output logic             grf_we,
   output logic             dm_we,
   output logic [1:0]       reg_dst,
   output logic [1:0]       wd_sel,
   output logic             alu_b_sel,
   output logic [1:0]       alu_op,
   output logic [1:0]       ext_op,
   output logic [1:0]       pc_src,
   output logic [2:0]       state,
   output logic             illegal,
   output logic [CNT_W-1:0] instr_cnt
);
   state_t     st, st_n;
   logic [2:0] cnt;
   logic       last, retire, dec_ill;
   cls_t       cls;
   ctl_t       c;

   mc_decode u_dec (.op(op), .funct(funct), .cls(cls), .ill(dec_ill));

   assign last = cnt == 3'(MEM_LAT - 1);

   always_comb begin
      st_n   = S_FETCH;
      c      = '0;
      retire = 1'b0;
      case (st)
         S_FETCH: begin
            c.ir_we = 1'b1;
            c.pc_we = 1'b1;
            st_n    = S_DECODE;
         end
         S_DECODE: begin
            st_n   = cls == C_JAL ? S_WB : dec_ill ? S_FETCH : S_EXE;
            retire = dec_ill;
         end
         S_EXE: case (cls)
            C_ADDU, C_SUBU: begin
               c.alu_op = cls == C_SUBU ? ALU_SUB : ALU_ADD;
               st_n     = S_WB;
            end
            C_ORI, C_LUI: begin
               c.alu_b_sel = 1'b1;
               c.ext_op    = cls == C_LUI ? EXT_LUI : EXT_ZERO;
               c.alu_op    = ALU_OR;
               st_n        = S_WB;
            end
            C_LW, C_SW: begin
               c.alu_b_sel = 1'b1;
               c.ext_op    = EXT_SIGN;
               st_n        = S_MEM;
            end
            C_BEQ: begin
               c.alu_op = ALU_SUB;
               c.pc_we  = zero;
               c.pc_src = PC_BR;
               retire   = 1'b1;
            end
            C_JR: begin
               c.pc_we  = 1'b1;
               c.pc_src = PC_RS;
               retire   = 1'b1;
            end
            C_NOP:   retire = 1'b1;
            default: ;
         endcase
         S_MEM: begin
            c.alu_b_sel = 1'b1;
            c.ext_op    = EXT_SIGN;
            c.dm_we     = last && cls == C_SW;
            retire      = c.dm_we;
            st_n        = !last ? S_MEM : cls == C_SW ? S_FETCH : S_WB;
         end
         S_WB: begin
            retire = 1'b1;
            case (cls)
               C_ADDU, C_SUBU: begin
                  c.grf_we  = 1'b1;
                  c.reg_dst = RD_RD;
                  c.alu_op  = cls == C_SUBU ? ALU_SUB : ALU_ADD;
               end
               C_ORI, C_LUI: begin
                  c.grf_we    = 1'b1;
                  c.alu_b_sel = 1'b1;
                  c.ext_op    = cls == C_LUI ? EXT_LUI : EXT_ZERO;
                  c.alu_op    = ALU_OR;
               end
               C_LW: begin
                  c.grf_we = 1'b1;
                  c.wd_sel = WD_DM;
               end
               C_JAL: begin
                  c.grf_we  = 1'b1;
                  c.reg_dst = RD_RA;
                  c.wd_sel  = WD_PC;
                  c.pc_we   = 1'b1;
                  c.pc_src  = PC_JAL;
               end
               default: ;
            endcase
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge reset)
      if (!reset) begin
         st        <= S_FETCH;
         cnt       <= '0;
         instr_cnt <= '0;
         illegal   <= 1'b0;
      end else begin
         st        <= st_n;
         cnt       <= (st == S_MEM && !last) ? cnt + 3'd1 : 3'd0;
         instr_cnt <= instr_cnt + CNT_W'(retire);
         illegal   <= illegal | (st == S_DECODE && dec_ill);
      end

   // reset low masks every strobe and select, not just the registered state
   assign {pc_we, ir_we, grf_we, dm_we, reg_dst, wd_sel, alu_b_sel, alu_op, ext_op, pc_src} =
      reset ? c : '0;
   assign state = st;
endmodule

// File: tb/tb_mc_ctrl.sv
// tb_mc_ctrl: per-instruction cycle-script model of the controller, checked every cycle
// under directed and random instruction streams, including a reset mid-lw.
module tb_mc_ctrl;
   localparam int L = 3;

   typedef struct packed {
      logic [2:0]  st;
      logic        pw, iw, gw, dw;
      logic [1:0]  rd, wd;
      logic        bs;
      logic [1:0]  ao, eo, ps;
      logic        ill;
      logic [31:0] cnt;
   } e_t;

   logic        clk = 1'b0, reset = 1'b0, zero = 1'b0;
   logic [5:0]  op = '0, funct = '0;
   logic        pc_we, ir_we, grf_we, dm_we, alu_b_sel, illegal;
   logic [1:0]  reg_dst, wd_sel, alu_op, ext_op, pc_src;
   logic [2:0]  state;
   logic [31:0] instr_cnt;
   int          total = 0, bad = 0;
   e_t          q[$];
   int          cnt_m = 0;
   bit          ill_m = 1'b0;
   e_t          g;

   mc_ctrl #(.MEM_LAT(L), .CNT_W(32)) dut (
      .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero),
      .pc_we(pc_we), .ir_we(ir_we), .grf_we(grf_we), .dm_we(dm_we),
      .reg_dst(reg_dst), .wd_sel(wd_sel), .alu_b_sel(alu_b_sel), .alu_op(alu_op),
      .ext_op(ext_op), .pc_src(pc_src), .state(state), .illegal(illegal),
      .instr_cnt(instr_cnt)
   );

   always #5 clk = ~clk;

   assign g = {state, pc_we, ir_we, grf_we, dm_we, reg_dst, wd_sel, alu_b_sel,
               alu_op, ext_op, pc_src, illegal, instr_cnt};

   always @(negedge clk)
      if (q.size() > 0) begin
         e_t e;
         e = q.pop_front();
         total++;
         if (g !== e) begin
            bad++;
            $display("FAIL cyc t=%0t got=%h exp=%h", $time, g, e);
         end
      end

   task automatic chk(input string n, input logic [31:0] a, input logic [31:0] x);
      total++;
      if (a !== x) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", n, a, x);
      end
   endtask

   // 0 addu 1 subu 2 ori 3 lui 4 lw 5 sw 6 beq 7 jal 8 jr 9 nop 10 illegal
   function automatic int cls(input logic [5:0] o, input logic [5:0] f);
      if (o == 6'h00)
         return f == 6'h21 ? 0 : f == 6'h23 ? 1 : f == 6'h08 ? 8 : f == 6'h00 ? 9 : 10;
      case (o)
         6'h0d: return 2;
         6'h0f: return 3;
         6'h23: return 4;
         6'h2b: return 5;
         6'h04: return 6;
         6'h03: return 7;
         default: return 10;
      endcase
   endfunction

   function automatic logic [11:0] pick(input int k);
      logic [5:0] o, f;
      f = 6'($urandom);
      case (k)
         0: begin o = 6'h00; f = 6'h21; end
         1: begin o = 6'h00; f = 6'h23; end
         2: o = 6'h0d;
         3: o = 6'h0f;
         4: o = 6'h23;
         5: o = 6'h2b;
         6: o = 6'h04;
         7: o = 6'h03;
         8: begin o = 6'h00; f = 6'h08; end
         9: begin o = 6'h00; f = 6'h00; end
         default: begin
            o = 6'($urandom);
            while (cls(o, f) != 10) begin
               o = 6'($urandom);
               f = 6'($urandom);
            end
         end
      endcase
      return {o, f};
   endfunction

   function automatic void put(input int s, input bit pw, iw, gw, dw, input int rd, wd,
                               input bit bs, input int ao, eo, ps);
      q.push_back({3'(s), pw, iw, gw, dw, 2'(rd), 2'(wd), bs, 2'(ao), 2'(eo), 2'(ps),
                   ill_m, 32'(cnt_m)});
   endfunction

   // entered just after the edge that starts this instruction's FETCH cycle
   task automatic run(input logic [5:0] o, input logic [5:0] f, input bit z);
      int k, n;
      k     = cls(o, f);
      op    = o;
      funct = f;
      zero  = z;
      put(0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
      put(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      case (k)
         0, 1: begin
            put(2, 0, 0, 0, 0, 0, 0, 0, k, 0, 0);
            put(4, 0, 0, 1, 0, 1, 0, 0, k, 0, 0);
         end
         2, 3: begin
            put(2, 0, 0, 0, 0, 0, 0, 1, 2, k == 3 ? 2 : 0, 0);
            put(4, 0, 0, 1, 0, 0, 0, 1, 2, k == 3 ? 2 : 0, 0);
         end
         4, 5: begin
            put(2, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0);
            for (int j = 0; j < L; j++) put(3, 0, 0, 0, k == 5 && j == L - 1, 0, 0, 1, 0, 1, 0);
            if (k == 4) put(4, 0, 0, 1, 0, 0, 1, 0, 0, 0, 0);
         end
         6: put(2, z, 0, 0, 0, 0, 0, 0, 1, 0, 1);
         7: put(4, 1, 0, 1, 0, 2, 2, 0, 0, 0, 2);
         8: put(2, 1, 0, 0, 0, 0, 0, 0, 0, 0, 3);
         9: put(2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
         default: ;
      endcase
      n = q.size();
      cnt_m++;
      ill_m = ill_m | (k == 10);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic rnd(input int cnt);
      logic [11:0] of;
      for (int i = 0; i < cnt; i++) begin
         of = pick($urandom_range(0, 10));
         run(of[11:6], of[5:0], 1'($urandom));
      end
   endtask

   initial begin
      repeat (3) @(posedge clk);
      #1;
      chk("rst_strb", 32'({pc_we, ir_we, grf_we, dm_we, reg_dst, wd_sel, alu_b_sel,
                           alu_op, ext_op, pc_src}), 32'd0);
      chk("rst_cnt", instr_cnt, 32'd0);
      reset = 1'b1;
      run(6'h00, 6'h21, 0);
      chk("cnt_after_addu", instr_cnt, 32'd1);
      run(6'h23, 6'h15, 0);
      run(6'h2b, 6'h3f, 1);
      run(6'h04, 6'h00, 1);
      run(6'h04, 6'h00, 0);
      run(6'h03, 6'h2a, 0);
      run(6'h00, 6'h08, 0);
      run(6'h3f, 6'h00, 0);
      chk("ill_sticky", 32'(illegal), 32'd1);
      run(6'h00, 6'h21, 1);
      run(6'h00, 6'h00, 0);
      run(6'h0d, 6'h11, 0);
      run(6'h0f, 6'h07, 1);
      run(6'h00, 6'h23, 0);
      chk("cnt_directed", instr_cnt, 32'd13);
      rnd(400);
      op    = 6'h23;
      funct = 6'h00;
      repeat (3) @(posedge clk);
      #1;
      chk("mid_mem_state", 32'(state), 32'd3);
      #2 reset = 1'b0;
      #1;
      chk("mid_rst_strb", 32'({pc_we, ir_we, grf_we, dm_we, reg_dst, wd_sel, alu_b_sel,
                               alu_op, ext_op, pc_src}), 32'd0);
      chk("mid_rst_cnt", instr_cnt, 32'd0);
      chk("mid_rst_state", 32'(state), 32'd0);
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b1;
      cnt_m = 0;
      ill_m = 1'b0;
      rnd(20);
      chk("cnt_after_rst", instr_cnt, 32'd20);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/mc_ctrl.md
Name: mc_ctrl

Overview:
- Multi-cycle control FSM for the MIPS datapath: PC/IR registers, GRF, EXT, ALU and DM are shared across cycles.
- Sequences each instruction through FETCH/DECODE/EXE/MEM/WB and drives every write strobe and mux select for that datapath.
- Supported instructions: addu, subu, ori, lui, lw, sw, beq, jal, jr, nop.
- Counts retired instructions and flags undecodable opcodes.

Parameters:
- MEM_LAT, 1, DM access cycles spent in S_MEM (legal range 1..7).
- CNT_W, 32, width of the retired-instruction counter.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- op  in  6  instr[31:26] from the IR.
- funct  in  6  instr[5:0] from the IR.
- zero  in  1  ALU result == 0.
- pc_we  out  1  PC write enable.
- ir_we  out  1  IR write enable.
- grf_we  out  1  GRF write enable.
- dm_we  out  1  DM write enable.
- reg_dst  out  2  GRF write address: 00 rt, 01 rd, 10 $31.
- wd_sel  out  2  GRF write data: 00 ALU, 01 DM, 10 PC (holds PC+4 after FETCH).
- alu_b_sel  out  1  ALU B input: 0 rt, 1 EXT.
- alu_op  out  2  00 add, 01 sub, 10 or.
- ext_op  out  2  00 zero-extend, 01 sign-extend, 10 imm<<16.
- pc_src  out  2  00 PC+4, 01 branch target, 10 jal target, 11 rs.
- state  out  3  current FSM state (debug).
- illegal  out  1  sticky: an unknown opcode/funct was decoded.
- instr_cnt  out  CNT_W  retired-instruction count.

Behaviour:
- Reset (reset==0, asynchronous):
  - state=S_FETCH, mem counter=0, instr_cnt=0, illegal=0.
  - All write strobes forced to 0 while reset is low. Selects read 0.
- Reset deasserted mid-instruction: the instruction is abandoned and the first cycle after release is S_FETCH.
- State encoding: S_FETCH=0, S_DECODE=1, S_EXE=2, S_MEM=3, S_WB=4. Codes 5..7 go to S_FETCH next cycle with no strobes.
- Outputs:
  - Strobes and selects are combinational from state, op, funct and zero.
  - instr_cnt and illegal are registered.
  - Any signal not listed for a state is 0.
- S_FETCH: ir_we=1, pc_we=1, pc_src=00. Next state S_DECODE.
- S_DECODE (op/funct are valid from this state on):
  - jal: next S_WB.
  - Recognised instructions: next S_EXE.
  - Unknown: set illegal, count the instruction as retired, next S_FETCH.
- S_EXE, per instruction:
  - addu (op 0, funct 0x21): alu_op=00, next S_WB.
  - subu (funct 0x23): alu_op=01, next S_WB.
  - nop (op 0, funct 0): no strobes, retire, next S_FETCH.
  - ori (0x0d): alu_b_sel=1, ext_op=00, alu_op=10, next S_WB.
  - lui (0x0f): alu_b_sel=1, ext_op=10, alu_op=10 (rs=0), next S_WB.
  - lw (0x23) / sw (0x2b): alu_b_sel=1, ext_op=01, alu_op=00, next S_MEM, mem counter=0.
  - beq (0x04): alu_op=01; pc_we=zero, pc_src=01; retire, next S_FETCH.
  - jr (op 0, funct 0x08): pc_we=1, pc_src=11; retire, next S_FETCH.
- S_MEM:
  - Holds the EXE selects (alu_b_sel=1, ext_op=01, alu_op=00) so the address stays stable.
  - Mem counter increments every cycle; the state exits when counter==MEM_LAT-1.
  - sw: dm_we=1 only in that final cycle; retire, next S_FETCH.
  - lw: next S_WB.
- S_WB:
  - addu/subu: grf_we=1, reg_dst=01, wd_sel=00; hold the EXE ALU selects.
  - ori/lui: grf_we=1, reg_dst=00, wd_sel=00; hold the EXE ALU selects.
  - lw: grf_we=1, reg_dst=00, wd_sel=01.
  - jal (0x03): grf_we=1, reg_dst=10, wd_sel=10, pc_we=1, pc_src=10. The GRF samples the old PC+4 on the same edge that PC updates.
  - All retire; next S_FETCH.
- Retire: instr_cnt increments by 1 on the clock edge leaving the instruction's last state; wraps modulo 2^CNT_W.
- Cycles per instruction:
  - addu/subu/ori/lui: 4.
  - lw: 4+MEM_LAT.
  - sw: 3+MEM_LAT.
  - beq/jr/nop: 3.
  - jal: 3.
  - illegal: 2.
- illegal clears only on reset.

Decomposition:
- Shared package mc_pkg:
  - state codes.
  - opcode/funct constants.
  - reg_dst / wd_sel / alu_op / ext_op / pc_src encodings, shared with the datapath muxes.
- One natural sub-module, mc_decode: combinational op/funct → instruction class plus illegal flag.
- mc_ctrl keeps the FSM, mem counter and retire counter.

Test Plan:
- Hold reset low 3 cycles, release → state=0, ir_we=pc_we=1 in the first cycle, instr_cnt=0; 4 cycles later with op=0, funct=0x21, the state trace is 0,1,2,4 and grf_we=1, reg_dst=01 only in state 4; instr_cnt=1.
- lw with MEM_LAT=3 → trace 0,1,2,3,3,3,4 (7 cycles), grf_we=1 with wd_sel=01 in the last cycle. sw with MEM_LAT=3 → 6 cycles, dm_we=1 in exactly the third S_MEM cycle.
- beq: zero=1 → pc_we=1, pc_src=01 in S_EXE. zero=0 → pc_we=0. Both take 3 cycles.
- jal → trace 0,1,4 with grf_we=1, reg_dst=10, wd_sel=10, pc_we=1, pc_src=10 together in S_WB. jr → pc_src=11, pc_we=1 in S_EXE.
- op=0x3f → illegal rises after S_DECODE and stays 1 through the following addu; instr_cnt counts both; no strobe other than FETCH's is asserted for the illegal instruction.
- Pull reset low during S_MEM of lw → strobes drop to 0 immediately, instr_cnt=0; after release, execution restarts at S_FETCH.
